// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decoder hold-register
// handshake and the control inputs that steer the fetch stage.
// The master modport is the fetch stage. The slave modport is its environment,
// meaning the memory, decoder and execute stage.
interface instr_fetch_if #(
    parameter int ADDR_W = 16
);
    // Instruction memory read port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    // Decoder hold-register handshake
    logic [31:0]       instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    // Control from decoder / execute, status back out
    logic              halt;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_target;
    logic              halted;

    modport master (
        output mem_req, mem_addr, instr, instr_valid, instr_pc, halted,
        input  mem_ack, mem_rdata, instr_ready, halt, branch_en, branch_target
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_valid, instr_pc, halted,
        output mem_ack, mem_rdata, instr_ready, halt, branch_en, branch_target
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. It owns the PC and reads one word at a time from
// instruction memory over req/ack. It holds each fetched word for the decoder
// behind a valid/ready register.
// Branch redirects that arrive while a read is outstanding are handled by
// draining the old request (DRAIN) before fetching the new target.
// All outputs come straight from registers. They are computed from the
// next-state values, so each output changes on the same edge as the state.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DRAIN  = 3'd2,
        S_HOLD   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    // State and datapath registers
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_drain_addr;   // address of the abandoned request being drained
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;

    // Registered outputs
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_instr_valid;
    logic              r_halted;

    // Next-state values
    state_t            w_next_state;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_next_drain_addr;
    logic [31:0]       w_next_instr;
    logic [ADDR_W-1:0] w_next_instr_pc;
    logic              w_next_mem_req;
    logic [ADDR_W-1:0] w_next_mem_addr;
    logic              w_next_instr_valid;
    logic              w_next_halted;
    logic [ADDR_W-1:0] w_pc_inc;

    // PC increment, wrapping naturally at 2^ADDR_W
    assign w_pc_inc = r_pc + ADDR_W'(1);

    // Next-state logic: transitions, PC updates and instruction capture
    always_comb begin
        w_next_state      = r_state;
        w_next_pc         = r_pc;
        w_next_drain_addr = r_drain_addr;
        w_next_instr      = r_instr;
        w_next_instr_pc   = r_instr_pc;

        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end

            S_FETCH: begin
                if (bus.mem_ack) begin
                    if (bus.branch_en) begin
                        // Data belongs to the wrong path; refetch from the target
                        w_next_pc    = bus.branch_target;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_instr    = bus.mem_rdata;
                        w_next_instr_pc = r_pc;
                        w_next_pc       = w_pc_inc;
                        w_next_state    = S_HOLD;
                    end
                end else if (bus.branch_en) begin
                    // The memory still owes us a reply for r_pc. Keep presenting
                    // it until acked, then throw the data away.
                    w_next_drain_addr = r_pc;
                    w_next_pc         = bus.branch_target;
                    w_next_state      = S_DRAIN;
                end else begin
                    w_next_state = S_FETCH;
                end
            end

            S_DRAIN: begin
                // The newest redirect wins, even while draining
                if (bus.branch_en) begin
                    w_next_pc = bus.branch_target;
                end else begin
                    w_next_pc = r_pc;
                end
                if (bus.mem_ack) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end

            S_HOLD: begin
                if (bus.branch_en) begin
                    w_next_pc    = bus.branch_target;
                    w_next_state = S_FETCH;
                end else if (bus.instr_ready) begin
                    if (bus.halt) begin
                        w_next_state = S_HALTED;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end else begin
                    w_next_state = S_HOLD;
                end
            end

            S_HALTED: begin
                w_next_state = S_HALTED;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the outputs can be registered
    always_comb begin
        w_next_mem_req     = 1'b0;
        w_next_mem_addr    = '0;
        w_next_instr_valid = 1'b0;
        w_next_halted      = 1'b0;

        case (w_next_state)
            S_FETCH: begin
                w_next_mem_req  = 1'b1;
                w_next_mem_addr = w_next_pc;
            end
            S_DRAIN: begin
                w_next_mem_req  = 1'b1;
                w_next_mem_addr = w_next_drain_addr;
            end
            S_HOLD: begin
                w_next_instr_valid = 1'b1;
            end
            S_HALTED: begin
                w_next_halted = 1'b1;
            end
            default: begin
                w_next_mem_req = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_drain_addr  <= '0;
            r_instr       <= 32'h0000_0000;
            r_instr_pc    <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_pc          <= w_next_pc;
            r_drain_addr  <= w_next_drain_addr;
            r_instr       <= w_next_instr;
            r_instr_pc    <= w_next_instr_pc;
            r_mem_req     <= w_next_mem_req;
            r_mem_addr    <= w_next_mem_addr;
            r_instr_valid <= w_next_instr_valid;
            r_halted      <= w_next_halted;
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch.
// u_dut1 runs with ADDR_W=16 and RESET_PC=0.
// u_dut2 runs with ADDR_W=4 and RESET_PC=0xD. It covers PC wrap and reset
// during an outstanding fetch.
// Inputs change just after each falling edge. Outputs are checked on the
// falling edge, half a cycle after the rising edge that produced them.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst;
    logic rst2;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model controls
    int   mem_lat = 0;       // wait cycles before ack for dut1
    logic hlt_en  = 1'b0;    // word 3 reads as HLT when set
    logic ack2_en = 1'b1;    // gate on dut2 memory ack
    int   wcnt    = 0;

    instr_fetch_if #(.ADDR_W(16)) bus1 ();
    instr_fetch_if #(.ADDR_W(4))  bus2 ();

    instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    instr_fetch #(.ADDR_W(4), .RESET_PC(4'hD)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.master)
    );

    always #5 clk = ~clk;

    // Wait-state counter for dut1 memory: counts cycles the current request has been pending
    always @(posedge clk) begin
        if (rst || !bus1.mem_req || bus1.mem_ack) wcnt <= 0;
        else                                      wcnt <= wcnt + 1;
    end

    // dut1 memory: word n = 0x0100_0000+n, optional HLT at word 3
    always_comb begin
        bus1.mem_ack   = bus1.mem_req && (wcnt >= mem_lat);
        bus1.mem_rdata = (hlt_en && bus1.mem_addr == 16'h0003) ? 32'h0B00_0000
                                                                : 32'h0100_0000 + {16'h0000, bus1.mem_addr};
    end

    // dut2 memory: zero-wait unless gated
    always_comb begin
        bus2.mem_ack   = bus2.mem_req && ack2_en;
        bus2.mem_rdata = 32'h0100_0000 + {28'h0000000, bus2.mem_addr};
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1_fetch(input string tag, input logic [15:0] addr);
        chk({tag, " req"},   64'(bus1.mem_req), 64'd1);
        chk({tag, " addr"},  64'(bus1.mem_addr), 64'(addr));
        chk({tag, " valid"}, 64'(bus1.instr_valid), 64'd0);
    endtask

    task automatic chk1_hold(input string tag, input logic [31:0] ins, input logic [15:0] pc);
        chk({tag, " valid"}, 64'(bus1.instr_valid), 64'd1);
        chk({tag, " req"},   64'(bus1.mem_req), 64'd0);
        chk({tag, " instr"}, 64'(bus1.instr), 64'(ins));
        chk({tag, " ipc"},   64'(bus1.instr_pc), 64'(pc));
    endtask

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        bus1.instr_ready = 1'b1;  bus1.halt = 1'b0;
        bus1.branch_en = 1'b0;    bus1.branch_target = 16'h0000;
        bus2.instr_ready = 1'b1;  bus2.halt = 1'b0;
        bus2.branch_en = 1'b0;    bus2.branch_target = 4'h0;

        // ---- Reset and sequential fetch ----
        tick(); tick();
        chk("rst req",    64'(bus1.mem_req), 64'd0);
        chk("rst valid",  64'(bus1.instr_valid), 64'd0);
        chk("rst halted", 64'(bus1.halted), 64'd0);
        chk("rst instr",  64'(bus1.instr), 64'd0);
        chk("rst ipc",    64'(bus1.instr_pc), 64'd0);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick(); chk1_fetch("seq fetch", 16'(n));
            tick(); chk1_hold("seq hold", 32'h0100_0000 + 32'(n), 16'(n));
        end

        // ---- Wait states and backpressure ----
        mem_lat = 3;
        bus1.instr_ready = 1'b0;
        bus1.instr_ready = 1'b1;           // let HOLD(3) hand off to FETCH(4)
        tick(); chk1_fetch("ws fetch", 16'h0004);
        bus1.instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); chk1_fetch("ws wait", 16'h0004);
        end
        for (int k = 0; k < 5; k++) begin
            tick(); chk1_hold("bp hold", 32'h0100_0004, 16'h0004);
        end
        bus1.instr_ready = 1'b1;

        // ---- Redirect while waiting ----
        tick(); chk1_fetch("rd fetch5", 16'h0005);        // 1st wait cycle
        tick(); chk1_fetch("rd wait2", 16'h0005);         // 2nd wait cycle
        bus1.branch_en = 1'b1; bus1.branch_target = 16'h0040;
        tick(); chk1_fetch("rd drain", 16'h0005);
        bus1.branch_en = 1'b0;
        tick(); chk1_fetch("rd drain ack", 16'h0005);
        tick(); chk1_fetch("rd target", 16'h0040);
        mem_lat = 0;
        tick(); chk1_hold("rd hold", 32'h0100_0040, 16'h0040);

        // ---- Redirect in HOLD, then redirect with same-cycle ack ----
        bus1.branch_en = 1'b1; bus1.branch_target = 16'h0010;
        tick(); chk1_fetch("hb fetch", 16'h0010);
        bus1.branch_target = 16'h0020;                    // ack is present this cycle
        tick(); chk1_fetch("ab fetch", 16'h0020);
        bus1.branch_en = 1'b0;
        tick(); chk1_hold("ab hold", 32'h0100_0020, 16'h0020);

        // ---- Halt ----
        hlt_en = 1'b1;
        bus1.branch_en = 1'b1; bus1.branch_target = 16'h0003;
        tick(); chk1_fetch("hlt fetch", 16'h0003);
        bus1.branch_en = 1'b0;
        tick(); chk1_hold("hlt hold", 32'h0B00_0000, 16'h0003);
        bus1.halt = 1'b1;
        tick();
        chk("hlt halted", 64'(bus1.halted), 64'd1);
        chk("hlt req",    64'(bus1.mem_req), 64'd0);
        chk("hlt valid",  64'(bus1.instr_valid), 64'd0);
        bus1.halt = 1'b0;
        bus1.branch_en = 1'b1; bus1.branch_target = 16'h0050;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hlt stay halted", 64'(bus1.halted), 64'd1);
            chk("hlt stay req",    64'(bus1.mem_req), 64'd0);
            chk("hlt stay valid",  64'(bus1.instr_valid), 64'd0);
        end
        bus1.branch_en = 1'b0;
        rst = 1'b1;
        hlt_en = 1'b0;
        tick();
        chk("hrst halted", 64'(bus1.halted), 64'd0);
        chk("hrst req",    64'(bus1.mem_req), 64'd0);
        chk("hrst valid",  64'(bus1.instr_valid), 64'd0);
        chk("hrst instr",  64'(bus1.instr), 64'd0);
        rst = 1'b0;
        tick(); chk1_fetch("hrst fetch", 16'h0000);
        tick(); chk1_hold("hrst hold", 32'h0100_0000, 16'h0000);

        // ---- ADDR_W=4: wrap, then reset with a request outstanding ----
        rst2 = 1'b0;
        for (int a = 13; a < 16; a++) begin
            tick();
            chk("w4 req",  64'(bus2.mem_req), 64'd1);
            chk("w4 addr", 64'(bus2.mem_addr), 64'(a));
            tick();
            chk("w4 valid", 64'(bus2.instr_valid), 64'd1);
            chk("w4 instr", 64'(bus2.instr), 64'(32'h0100_0000 + 32'(a)));
            chk("w4 ipc",   64'(bus2.instr_pc), 64'(a));
        end
        ack2_en = 1'b0;
        tick();
        chk("wrap req",  64'(bus2.mem_req), 64'd1);
        chk("wrap addr", 64'(bus2.mem_addr), 64'd0);
        tick();
        chk("wrap stall addr", 64'(bus2.mem_addr), 64'd0);
        rst2 = 1'b1;
        tick();
        chk("mrst req",   64'(bus2.mem_req), 64'd0);
        chk("mrst valid", 64'(bus2.instr_valid), 64'd0);
        chk("mrst addr",  64'(bus2.mem_addr), 64'd0);
        rst2 = 1'b0;
        ack2_en = 1'b1;
        tick();
        chk("mrst fetch req",  64'(bus2.mem_req), 64'd1);
        chk("mrst fetch addr", 64'(bus2.mem_addr), 64'hD);
        tick();
        chk("mrst hold valid", 64'(bus2.instr_valid), 64'd1);
        chk("mrst hold instr", 64'(bus2.instr), 64'h0100_000D);
        chk("mrst hold ipc",   64'(bus2.instr_pc), 64'hD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the simple CPU; sits directly upstream of the decoder.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents one 32-bit instruction at a time to the decoder through a valid/ready hold register.
- Consumes the decoder's halt and the execute stage's branch redirect.

Parameters:
- ADDR_W, 16, PC / memory word-address width.
- RESET_PC, 0, PC value loaded on reset; must fit in ADDR_W bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  ADDR_W  word address of the request.
- mem_ack  input  1  read data valid this cycle; may rise in the same cycle as mem_req.
- mem_rdata  input  32  instruction word, valid when mem_ack=1.
- instr  output  32  held instruction word, drives the decoder's instr input.
- instr_valid  output  1  instr holds a live instruction; drives the decoder's en input.
- instr_pc  output  ADDR_W  address of the held instruction.
- instr_ready  input  1  downstream consumes instr this cycle.
- halt  input  1  decoder's halt flag; sampled only at handshake.
- branch_en  input  1  one-cycle redirect pulse.
- branch_target  input  ADDR_W  redirect address.
- halted  output  1  fetch stopped by HLT.

Behaviour:
- States: IDLE, FETCH, DRAIN, HOLD, HALTED. All registers update on clk rising edge.
- Reset (rst=1 at an edge, in any state):
  - state<=IDLE, pc<=RESET_PC.
  - Next cycle: instr_valid=0, mem_req=0, halted=0, instr=0, instr_pc=0.
  - Any in-flight request is abandoned. Instruction memory shares rst and drops it too.
- IDLE: mem_req=0; always goes to FETCH on the next edge.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - mem_req and mem_addr stay stable until mem_ack.
  - On mem_ack with no branch_en: instr<=mem_rdata, instr_pc<=pc, pc<=pc+1 (wraps mod 2^ADDR_W), go to HOLD.
  - On mem_ack with branch_en in the same cycle: discard the data, pc<=branch_target, stay in FETCH. The request to the target starts next cycle.
  - On branch_en without mem_ack: pc<=branch_target, go to DRAIN.
- DRAIN:
  - mem_req=1, mem_addr = the old address, which is held in a separate latched-address register.
  - On mem_ack: discard the data, go to FETCH (fetches branch_target).
  - A further branch_en in DRAIN overwrites pc; the newest target wins.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable; mem_req=0.
  - Priority in HOLD: branch_en > halt > instr_ready.
  - branch_en: drop instr (instr_valid=0 next cycle), pc<=branch_target, go to FETCH.
  - instr_ready=1 and halt=1: go to HALTED.
  - instr_ready=1 and halt=0: go to FETCH.
  - instr_ready=0: stay in HOLD, outputs unchanged.
- HALTED:
  - instr_valid=0, mem_req=0, halted=1.
  - Ignores branch_en, instr_ready and mem_ack; leaves only on rst.
- halt is ignored outside HOLD.
- instr_valid is 1 exactly when state==HOLD. mem_req is 1 exactly when state is FETCH or DRAIN.
- Timing:
  - Zero-wait memory: instr_valid rises the cycle after the ack edge.
  - Steady throughput with instr_ready tied high: 1 instruction per 2 cycles.
  - Latency from rst release to first instr_valid: 3 cycles (IDLE, FETCH, HOLD).
- mem_ack outside FETCH/DRAIN is ignored.
- mem_addr = pc in FETCH, latched address in DRAIN, 0 otherwise.

Test Plan:
- Reset/sequential fetch: rst 2 cycles; memory zero-wait, word n = 0x0100_0000+n; instr_ready=1. Expect mem_addr 0,1,2,3; instr_valid pulses on alternate cycles; instr/instr_pc = 0x01000000/0, 0x01000001/1, ...
- Backpressure + wait states: mem_ack delayed 3 cycles; instr_ready low 4 cycles. Expect mem_req and mem_addr stable throughout; instr held unchanged 5 cycles; pc advances by exactly 1.
- Redirect while waiting: branch_en with target 0x0040 in the 2nd wait cycle of a fetch at 0x0005. Expect req held at 0x0005 until ack; data discarded; next mem_addr=0x0040; no instr_valid for 0x0005.
- Redirect in HOLD/same-cycle ack: branch_en with target 0x0010 while HOLD, instr_ready=1. Expect instr dropped, next fetch 0x0010. Then branch_en with target 0x0020 coinciding with mem_ack. Expect data dropped, next fetch 0x0020.
- Halt: word 3 = 0x0B00_0000 (opcode HLT); decoder halt=1 with ready. Expect halted=1, mem_req=0 forever, branch_en ignored; rst returns to fetch at RESET_PC.
- Wrap/reset mid-fetch: ADDR_W=4, fetch at 0xF. Expect next mem_addr 0x0. Then assert rst during an outstanding request. Expect mem_req=0, instr_valid=0 next cycle; restart at RESET_PC.
